nanci_pe_cx: RTL and testbench

Parametrised mesh processing element for the Nanci sorting array, succeeding the fixed-width select-only PE. Holds one keyed word and, under a per-cycle opcode from the array controller, selects a neighbour's word, performs a min/max compare-exchange against a neighbour, loads a word, or runs a self-timed burst of compare-exchanges. A busy/ready handshake covers bursts, and the PE counts successful swaps for convergence detection. Instantiated once per mesh cell, with its output fanned out to its four neighbours.

---
 rtl/nanci_pkg.sv | 30 +++
 rtl/nanci_cx_cmp.sv | 21 ++
 rtl/nanci_pe_cx.sv | 126 ++++++++++++
 tb/tb_nanci_pe_cx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nanci_pkg.sv
// Shared types for the Nanci sorting-array processing element.
package nanci_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_SEL   = 3'd1,
    OP_CX    = 3'd2,
    OP_LOAD  = 3'd3,
    OP_BURST = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Direction and ordering captured when a burst is accepted.
  typedef struct packed {
    dir_e dir;
    logic keep_min;
  } burst_ctx_t;

endpackage

// File: rtl/nanci_cx_cmp.sv
// Min/max compare-exchange on the key field; ties keep the own word.
module nanci_cx_cmp #(
  parameter int KEY_WIDTH  = 3,
  parameter int DATA_WIDTH = 3
) (
  input  logic [KEY_WIDTH+DATA_WIDTH-1:0] own,
  input  logic [KEY_WIDTH+DATA_WIDTH-1:0] nbr,
  input  logic                            keep_min,
  output logic [KEY_WIDTH+DATA_WIDTH-1:0] sel_word,
  output logic                            swap
);
  localparam int W = KEY_WIDTH + DATA_WIDTH;

  logic [KEY_WIDTH-1:0] own_key, nbr_key;

  assign own_key  = own[W-1 -: KEY_WIDTH];
  assign nbr_key  = nbr[W-1 -: KEY_WIDTH];
  assign swap     = keep_min ? (nbr_key < own_key) : (nbr_key > own_key);
  assign sel_word = swap ? nbr : own;

endmodule

// File: rtl/nanci_pe_cx.sv
// Mesh PE: holds one keyed word; select/compare-exchange/load/burst under opcode control.
module nanci_pe_cx
  import nanci_pkg::*;
#(
  parameter int                            KEY_WIDTH  = 3,
  parameter int                            DATA_WIDTH = 3,
  parameter int                            CNT_WIDTH  = 4,
  parameter logic [KEY_WIDTH+DATA_WIDTH-1:0] RESET_WORD = '0,
  parameter logic [3:0]                    EDGE_MASK  = 4'b0000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [KEY_WIDTH+DATA_WIDTH-1:0] i_PE_l,
  input  logic [KEY_WIDTH+DATA_WIDTH-1:0] i_PE_r,
  input  logic [KEY_WIDTH+DATA_WIDTH-1:0] i_PE_u,
  input  logic [KEY_WIDTH+DATA_WIDTH-1:0] i_PE_d,
  input  logic [2:0]                      i_op,
  input  logic [1:0]                      i_dir,
  input  logic                            i_keep_min,
  input  logic [CNT_WIDTH-1:0]            i_count,
  input  logic [KEY_WIDTH+DATA_WIDTH-1:0] i_load_word,
  input  logic                            i_op_valid,
  output logic                            o_ready,
  output logic [KEY_WIDTH+DATA_WIDTH-1:0] o_PE,
  output logic [CNT_WIDTH-1:0]            o_swaps
);
  localparam int W = KEY_WIDTH + DATA_WIDTH;

  state_e               state;
  burst_ctx_t           ctx;
  logic [CNT_WIDTH-1:0] remaining;
  logic [W-1:0]         word;
  logic [CNT_WIDTH-1:0] swaps;

  dir_e                 dir_sel;
  logic                 keep_sel;
  logic [W-1:0]         nbr;
  logic                 masked;
  logic [W-1:0]         cx_word;
  logic                 cx_swap;
  logic [CNT_WIDTH-1:0] swaps_inc;

  // A running burst steers the shared comparator with its latched context.
  assign dir_sel  = (state == ST_BUSY) ? ctx.dir : dir_e'(i_dir);
  assign keep_sel = (state == ST_BUSY) ? ctx.keep_min : i_keep_min;
  assign masked   = EDGE_MASK[dir_sel];

  always_comb begin
    nbr = i_PE_l;
    case (dir_sel)
      DIR_L: nbr = i_PE_l;
      DIR_R: nbr = i_PE_r;
      DIR_U: nbr = i_PE_u;
      DIR_D: nbr = i_PE_d;
      default: nbr = i_PE_l;
    endcase
  end

  nanci_cx_cmp #(
    .KEY_WIDTH (KEY_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .own     (word),
    .nbr     (nbr),
    .keep_min(keep_sel),
    .sel_word(cx_word),
    .swap    (cx_swap)
  );

  assign swaps_inc = (&swaps) ? swaps : swaps + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ctx       <= '{dir: DIR_L, keep_min: 1'b0};
      remaining <= '0;
      word      <= RESET_WORD;
      swaps     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_op_valid) begin
            case (i_op)
              OP_SEL: begin
                if (!masked) word <= nbr;
              end
              OP_CX: begin
                if (!masked && cx_swap) begin
                  word  <= cx_word;
                  swaps <= swaps_inc;
                end
              end
              OP_LOAD: begin
                word  <= i_load_word;
                swaps <= '0;
              end
              OP_BURST: begin
                if (i_count != '0) begin
                  ctx       <= '{dir: dir_e'(i_dir), keep_min: i_keep_min};
                  remaining <= i_count;
                  state     <= ST_BUSY;
                end
              end
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          // Masked bursts still run to completion so array timing stays uniform.
          if (!masked && cx_swap) begin
            word  <= cx_word;
            swaps <= swaps_inc;
          end
          remaining <= remaining - 1'b1;
          if (remaining == 1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_PE    = word;
  assign o_swaps = swaps;

endmodule

// File: tb/tb_nanci_pe_cx.sv
// Bench for nanci_pe_cx: an unmasked and an L-masked instance against a behavioural model.
module tb_nanci_pe_cx;
  localparam int W  = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  pl, pr, pu, pd, load_word;
  logic [2:0]    op;
  logic [1:0]    dir;
  logic          keep_min, op_valid;
  logic [CW-1:0] count;

  logic [W-1:0]  o_pe  [2];
  logic [CW-1:0] o_sw  [2];
  logic          o_rdy [2];

  int checks = 0;
  int errors = 0;

  // Model state: word, swap count, cycles left in a burst and its context.
  logic [W-1:0] mw   [2];
  int           ms   [2];
  int           mrem [2];
  int           mdir [2];
  bit           mkm  [2];
  logic [3:0]   mask [2] = '{4'b0000, 4'b0001};

  always #5 clk = ~clk;

  nanci_pe_cx dut0 (
    .clk(clk), .rst(rst),
    .i_PE_l(pl), .i_PE_r(pr), .i_PE_u(pu), .i_PE_d(pd),
    .i_op(op), .i_dir(dir), .i_keep_min(keep_min), .i_count(count),
    .i_load_word(load_word), .i_op_valid(op_valid),
    .o_ready(o_rdy[0]), .o_PE(o_pe[0]), .o_swaps(o_sw[0])
  );

  nanci_pe_cx #(.EDGE_MASK(4'b0001)) dut1 (
    .clk(clk), .rst(rst),
    .i_PE_l(pl), .i_PE_r(pr), .i_PE_u(pu), .i_PE_d(pd),
    .i_op(op), .i_dir(dir), .i_keep_min(keep_min), .i_count(count),
    .i_load_word(load_word), .i_op_valid(op_valid),
    .o_ready(o_rdy[1]), .o_PE(o_pe[1]), .o_swaps(o_sw[1])
  );

  function automatic logic [W-1:0] nbr_of(int d);
    case (d)
      0: return pl;
      1: return pr;
      2: return pu;
      default: return pd;
    endcase
  endfunction

  task automatic model_cx(int k, int d, bit km);
    logic [W-1:0] n;
    int nk, ok;
    if (mask[k][d]) return;
    n  = nbr_of(d);
    nk = int'(n[5:3]);
    ok = int'(mw[k][5:3]);
    if (km ? (nk < ok) : (nk > ok)) begin
      mw[k] = n;
      if (ms[k] < 15) ms[k]++;
    end
  endtask

  // Advance one clock; the model consumes the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mw[k] = '0; ms[k] = 0; mrem[k] = 0;
      end else if (mrem[k] > 0) begin
        model_cx(k, mdir[k], mkm[k]);
        mrem[k]--;
      end else if (op_valid) begin
        case (op)
          3'd1: if (!mask[k][dir]) mw[k] = nbr_of(int'(dir));
          3'd2: model_cx(k, int'(dir), keep_min);
          3'd3: begin mw[k] = load_word; ms[k] = 0; end
          3'd4: if (count != 0) begin
            mrem[k] = int'(count); mdir[k] = int'(dir); mkm[k] = keep_min;
          end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic issue(logic [2:0] o, logic [1:0] d, logic km, logic [CW-1:0] c, logic [W-1:0] lw);
    op = o; dir = d; keep_min = km; count = c; load_word = lw; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    checks++; if (o_pe[0] !== 6'b000000) begin errors++; $display("FAIL reset_word got %b want %b", o_pe[0], 6'b0); end
    checks++; if (o_sw[0] !== 4'd0) begin errors++; $display("FAIL reset_swaps got %0d want 0", o_sw[0]); end
    checks++; if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_rdy[0]); end
  endtask

  task automatic test_sel();
    issue(3'd1, 2'd0, 1'b0, 4'd0, '0);
    checks++; if (o_pe[0] !== 6'b001000) begin errors++; $display("FAIL sel_l got %b want %b", o_pe[0], 6'b001000); end
    checks++; if (o_rdy[0] !== 1'b1 || o_sw[0] !== 4'd0) begin errors++; $display("FAIL sel_status got rdy=%b sw=%0d want rdy=1 sw=0", o_rdy[0], o_sw[0]); end
    issue(3'd1, 2'd3, 1'b0, 4'd0, '0);
    checks++; if (o_pe[0] !== mw[0]) begin errors++; $display("FAIL sel_d got %b want %b", o_pe[0], mw[0]); end
  endtask

  task automatic test_cx();
    issue(3'd3, 2'd0, 1'b0, 4'd0, 6'b010101);
    issue(3'd2, 2'd3, 1'b1, 4'd0, '0);
    checks++; if (o_pe[0] !== 6'b010101 || o_sw[0] !== 4'd0) begin errors++; $display("FAIL cx_d_min got %b/%0d want 010101/0", o_pe[0], o_sw[0]); end
    issue(3'd2, 2'd0, 1'b1, 4'd0, '0);
    checks++; if (o_pe[0] !== 6'b001000 || o_sw[0] !== 4'd1) begin errors++; $display("FAIL cx_l_min got %b/%0d want 001000/1", o_pe[0], o_sw[0]); end
    issue(3'd3, 2'd0, 1'b0, 4'd0, 6'b011111);
    issue(3'd2, 2'd2, 1'b0, 4'd0, '0);
    checks++; if (o_pe[0] !== 6'b011111 || o_sw[0] !== 4'd0) begin errors++; $display("FAIL cx_tie got %b/%0d want 011111/0", o_pe[0], o_sw[0]); end
    issue(3'd2, 2'd3, 1'b0, 4'd0, '0);
    checks++; if (o_pe[0] !== 6'b100000 || o_sw[0] !== 4'd1) begin errors++; $display("FAIL cx_d_max got %b/%0d want 100000/1", o_pe[0], o_sw[0]); end
  endtask

  task automatic test_saturate();
    issue(3'd3, 2'd0, 1'b0, 4'd0, 6'b011000);
    for (int i = 0; i < 20; i++) issue(3'd2, (i % 2 == 0) ? 2'd0 : 2'd1, (i % 2 == 0), 4'd0, '0);
    checks++; if (o_sw[0] !== 4'd15) begin errors++; $display("FAIL swaps_sat got %0d want 15", o_sw[0]); end
    checks++; if (o_pe[0] !== mw[0]) begin errors++; $display("FAIL sat_word got %b want %b", o_pe[0], mw[0]); end
  endtask

  task automatic test_burst();
    int n = 0;
    issue(3'd3, 2'd0, 1'b0, 4'd0, 6'b111000);
    issue(3'd4, 2'd0, 1'b1, 4'd3, '0);
    for (int i = 0; i < 20; i++) begin
      if (o_rdy[0]) break;
      n++;
      if (n == 2) begin
        pl = 6'b000111;
        op = 3'd3; load_word = 6'b110110; op_valid = 1'b1;
      end
      tick();
      op_valid = 1'b0;
      checks++; if (o_pe[0] !== mw[0] || o_sw[0] !== ms[0][CW-1:0]) begin errors++; $display("FAIL burst_step%0d got %b/%0d want %b/%0d", n, o_pe[0], o_sw[0], mw[0], ms[0]); end
      checks++; if (o_pe[1] !== 6'b111000) begin errors++; $display("FAIL burst_masked_word got %b want 111000", o_pe[1]); end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL burst_busy_cycles got %0d want 3", n); end
    checks++; if (o_pe[0] !== 6'b000111 || o_sw[0] !== 4'd2) begin errors++; $display("FAIL burst_result got %b/%0d want 000111/2", o_pe[0], o_sw[0]); end
    pl = 6'b001000;
    issue(3'd4, 2'd1, 1'b0, 4'd0, '0);
    checks++; if (o_rdy[0] !== 1'b1 || o_pe[0] !== 6'b000111) begin errors++; $display("FAIL burst_zero got rdy=%b %b want rdy=1 000111", o_rdy[0], o_pe[0]); end
  endtask

  task automatic test_edge_mask();
    int n = 0;
    issue(3'd3, 2'd0, 1'b0, 4'd0, 6'b101010);
    issue(3'd1, 2'd0, 1'b0, 4'd0, '0);
    checks++; if (o_pe[1] !== 6'b101010) begin errors++; $display("FAIL mask_sel got %b want 101010", o_pe[1]); end
    checks++; if (o_pe[0] !== 6'b001000) begin errors++; $display("FAIL unmask_sel got %b want 001000", o_pe[0]); end
    issue(3'd4, 2'd0, 1'b1, 4'd2, '0);
    for (int i = 0; i < 20; i++) begin
      if (o_rdy[1]) break;
      n++;
      tick();
    end
    checks++; if (n != 2) begin errors++; $display("FAIL mask_burst_cycles got %0d want 2", n); end
    checks++; if (o_pe[1] !== 6'b101010 || o_sw[1] !== 4'd0) begin errors++; $display("FAIL mask_burst_word got %b/%0d want 101010/0", o_pe[1], o_sw[1]); end
    issue(3'd2, 2'd1, 1'b0, 4'd0, '0);
    checks++; if (o_pe[1] !== 6'b101010 || o_sw[1] !== 4'd0) begin errors++; $display("FAIL mask_cx_r got %b/%0d want 101010/0", o_pe[1], o_sw[1]); end
  endtask

  task automatic test_reset_mid_burst();
    issue(3'd3, 2'd0, 1'b0, 4'd0, 6'b111000);
    issue(3'd4, 2'd0, 1'b1, 4'd5, '0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (o_pe[0] !== 6'b000000 || o_sw[0] !== 4'd0 || o_rdy[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_burst got %b/%0d/%b want 000000/0/1", o_pe[0], o_sw[0], o_rdy[0]); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (o_pe[0] !== 6'b000000 || o_rdy[0] !== 1'b1) begin errors++; $display("FAIL rst_after%0d got %b/%b want 000000/1", i, o_pe[0], o_rdy[0]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pl = 6'($urandom); pr = 6'($urandom); pu = 6'($urandom); pd = 6'($urandom);
      op = 3'($urandom_range(0, 7)); dir = 2'($urandom); keep_min = 1'($urandom);
      count = 4'($urandom_range(0, 5)); load_word = 6'($urandom);
      op_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) != 0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
        checks++; if (o_pe[k] !== mw[k]) begin errors++; $display("FAIL rand_word[%0d] cyc %0d got %b want %b", k, i, o_pe[k], mw[k]); end
        checks++; if (o_sw[k] !== ms[k][CW-1:0]) begin errors++; $display("FAIL rand_swaps[%0d] cyc %0d got %0d want %0d", k, i, o_sw[k], ms[k]); end
        checks++; if (o_rdy[k] !== (mrem[k] == 0)) begin errors++; $display("FAIL rand_ready[%0d] cyc %0d got %b want %b", k, i, o_rdy[k], mrem[k] == 0); end
      end
    end
  endtask

  initial begin
    pl = 6'b001000; pr = 6'b010000; pu = 6'b011000; pd = 6'b100000;
    op = 3'd0; dir = 2'd0; keep_min = 1'b0; count = '0; load_word = '0; op_valid = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin mw[k] = '0; ms[k] = 0; mrem[k] = 0; mdir[k] = 0; mkm[k] = 0; end
    @(negedge clk);
    test_reset();
    test_sel();
    test_cx();
    test_saturate();
    test_burst();
    test_edge_mask();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
